// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Purpose:
//   Register-hazard scheduler for the issue stage. It tracks up to DEPTH
//   in-flight register writebacks. Each one is identified by a 6-bit
//   register index: a bank bit plus a 5-bit register number.
//   An issuing instruction is held back in three cases:
//     - one of its sources matches a pending writeback (RAW);
//     - its destination matches a pending writeback (WAW);
//     - it needs an entry and the table is full.
//   A writeback frees the lowest-numbered entry holding its index.
//
// Optional feature (compile-time macro SCOREBOARD_WB_BYPASS_EN):
//   Defined   - a writeback arriving in the same cycle masks the entry it
//               retires out of the hazard and full terms. A dependent
//               instruction can then issue in the writeback cycle.
//   Undefined - hazards use the registered valid bits only.
//
// Ports:
//   sys_clk        in   clock, rising edge
//   resetl         in   asynchronous active-low reset
//   flush          in   synchronous clear of every entry (abort)
//   iss_valid      in   issue request
//   iss_ready      out  issue accepted when iss_valid & iss_ready
//   iss_srca/_used in   source A index / takes part in the hazard check
//   iss_srcb/_used in   source B index / takes part in the hazard check
//   iss_dst/_used  in   destination index / allocates an entry, WAW-checked
//   wb_valid       in   writeback completing this cycle
//   wb_idx         in   register index being written back
//   wb_err         out  one-cycle pulse: the writeback matched no entry
//   full           out  every entry valid
//   pend_cnt       out  number of valid entries
//   stall_cnt      out  consecutive stall cycles, saturating
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int DEPTH = 4,
    parameter int IDXW  = 6,
    parameter int SCW   = 8
) (
    input  logic            sys_clk,
    input  logic            resetl,
    input  logic            flush,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [IDXW-1:0] iss_srca,
    input  logic            iss_srca_used,
    input  logic [IDXW-1:0] iss_srcb,
    input  logic            iss_srcb_used,
    input  logic [IDXW-1:0] iss_dst,
    input  logic            iss_dst_used,
    input  logic            wb_valid,
    input  logic [IDXW-1:0] wb_idx,
    output logic            wb_err,
    output logic            full,
    output logic [3:0]      pend_cnt,
    output logic [SCW-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
    logic            wb_err_q, wb_err_d;
    logic            full_q, full_d;
    logic [3:0]      pend_cnt_q, pend_cnt_d;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDXW-1:0]  idx_q [DEPTH];
    logic [IDXW-1:0]  idx_d [DEPTH];

    logic [DEPTH-1:0] match_wb;
    logic [DEPTH-1:0] match_srca;
    logic [DEPTH-1:0] match_srcb;
    logic [DEPTH-1:0] match_dst;
    logic [DEPTH-1:0] wb_sel;
    logic [DEPTH-1:0] wb_clr;
    logic [DEPTH-1:0] haz_valid;
    logic [DEPTH-1:0] alloc_sel;

    logic wb_live;
    logic wb_hit;
    logic hazard;
    logic full_term;
    logic ready_int;
    logic accept;
    logic alloc;

    // Isolate the lowest set bit (one-hot, or zero when the input is zero).
    function automatic logic [DEPTH-1:0] lowest_one(input logic [DEPTH-1:0] v);
        return v & (~v + DEPTH'(1));
    endfunction

    // -----------------------------------------------------------------------
    // Writeback lookup against the registered (pre-writeback) state
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wb_match
            assign match_wb[gi] = valid_q[gi] & (idx_q[gi] == wb_idx);
        end
    endgenerate

    assign wb_sel = lowest_one(match_wb);
    assign wb_hit = |match_wb;

    // A writeback is dropped when an abort is requested this cycle.
    // It is also dropped while the abort cycle itself is in progress.
    assign wb_live = wb_valid & ~flush & (state_q != ST_FLUSH);
    assign wb_clr  = wb_live ? wb_sel : '0;

    // -----------------------------------------------------------------------
    // Hazard compare: every operand against every entry, all 6 bits equal
    // -----------------------------------------------------------------------
`ifdef SCOREBOARD_WB_BYPASS_EN
    // The entry retiring this cycle no longer blocks anything.
    assign haz_valid = valid_q & ~wb_clr;
`else
    assign haz_valid = valid_q;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_haz_match
            assign match_srca[gi] = haz_valid[gi] & (idx_q[gi] == iss_srca);
            assign match_srcb[gi] = haz_valid[gi] & (idx_q[gi] == iss_srcb);
            assign match_dst[gi]  = haz_valid[gi] & (idx_q[gi] == iss_dst);
        end
    endgenerate

    assign hazard = (iss_srca_used & (|match_srca))
                  | (iss_srcb_used & (|match_srcb))
                  | (iss_dst_used  & (|match_dst));

    // Matches the registered full flag unless the bypass masks an entry.
    assign full_term = &haz_valid;

    // Issue is evaluated in both RUN and STALL; only the abort cycle blocks.
    assign ready_int = (state_q != ST_FLUSH) & ~flush & ~hazard
                     & ~(full_term & iss_dst_used);

    // Held low for as long as reset is asserted, even though the state
    // already reads as RUN with an empty table.
    assign iss_ready = resetl & ready_int;

    assign accept = iss_valid & iss_ready;
    assign alloc  = accept & iss_dst_used;

    // -----------------------------------------------------------------------
    // Allocation: lowest entry free in the pre-writeback state. An entry
    // retiring this cycle is still valid there, so it is never chosen.
    // -----------------------------------------------------------------------
`ifdef SCOREBOARD_WB_BYPASS_EN
    // With bypass, a full table can accept a destination in the same cycle
    // that one entry retires. No entry is free before the writeback then,
    // so the retiring slot is the only place the new index can go.
    assign alloc_sel = (|(~valid_q)) ? lowest_one(~valid_q) : wb_clr;
`else
    assign alloc_sel = lowest_one(~valid_q);
`endif

    // -----------------------------------------------------------------------
    // Entry next state
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            valid_d = valid_q & ~wb_clr;
            if (alloc) begin
                valid_d = valid_d | alloc_sel;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_idx_next
            assign idx_d[gi] = (alloc & alloc_sel[gi]) ? iss_dst : idx_q[gi];
        end
    endgenerate

    // Status flags come from the same next-state bits as the valid
    // registers, so they change on the same edge as the table itself.
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + {3'b000, valid_d[i]};
        end
    end

    assign full_d   = &valid_d;
    assign wb_err_d = wb_live & ~wb_hit;

    // -----------------------------------------------------------------------
    // Control FSM and stall counter
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (iss_valid & ~iss_ready) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (accept | ~iss_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The counter advances once for each cycle spent in STALL that
        // ends still in STALL. Leaving STALL for RUN or FLUSH clears it.
        // So the first STALL cycle reads 0.
        if (state_d != ST_STALL) begin
            stall_cnt_d = '0;
        end else if ((state_q == ST_STALL) && (stall_cnt_q != {SCW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + SCW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            wb_err_q    <= 1'b0;
            full_q      <= 1'b0;
            pend_cnt_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            wb_err_q    <= wb_err_d;
            full_q      <= full_d;
            pend_cnt_q  <= pend_cnt_d;
            valid_q     <= valid_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_idx_reg
            always_ff @(posedge sys_clk or negedge resetl) begin
                if (!resetl) begin
                    idx_q[gi] <= '0;
                end else begin
                    idx_q[gi] <= idx_d[gi];
                end
            end
        end
    endgenerate

    assign wb_err    = wb_err_q;
    assign full      = full_q;
    assign pend_cnt  = pend_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
